// File: rtl/seven_seg_digit_driver_if.sv
// Producer-to-display bus for seven_seg_digit_driver.
// Carries one display frame per valid/ready transfer:
//   value       - four hex digits, value[3:0] is digit 0
//   dp_in       - decimal point per digit, 1 = lit
//   blank_lz    - leading-zero blanking for this frame
//   value_valid - producer has a frame on the bus
//   value_ready - driver can accept a frame; transfer when valid && ready
interface seven_seg_digit_driver_if;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic        value_valid;
  logic        value_ready;

  modport master (
    output value,
    output dp_in,
    output blank_lz,
    output value_valid,
    input  value_ready
  );

  modport slave (
    input  value,
    input  dp_in,
    input  blank_lz,
    input  value_valid,
    output value_ready
  );
endinterface

// File: rtl/seven_seg_digit_driver.sv
// Seven-segment cathode driver for a four-digit scanned display.
// Follows the scanner's active-low one-hot anode rotation and drives the segments of the
// selected digit. Frames arrive through a valid/ready bus into a pending buffer and are
// committed to the display register only at frame boundaries, so a frame never tears.
// Ports:
//   clock      - system clock
//   reset      - synchronous, active-high
//   anode      - scanner anodes, active-low one-hot, asynchronous to clock
//   bus        - frame input (value, dp_in, blank_lz, value_valid / value_ready)
//   seg        - cathodes, active-low, {g,f,e,d,c,b,a}
//   dp         - decimal point cathode, active-low
//   frame_tick - one-cycle pulse when the scan re-enters digit 0
//   anode_err  - sticky flag: an illegal anode pattern was seen
module seven_seg_digit_driver (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [3:0]                     anode,
  seven_seg_digit_driver_if.slave        bus,
  output logic [6:0]                     seg,
  output logic                           dp,
  output logic                           frame_tick,
  output logic                           anode_err
);

  localparam logic [3:0] AnodeDigit0 = 4'b1110;

  logic [3:0]  s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic        pending_q, pending_d;
  logic [15:0] buf_value_q, buf_value_d, disp_value_q, disp_value_d;
  logic [3:0]  buf_dp_q, buf_dp_d, disp_dp_q, disp_dp_d;
  logic        buf_blz_q, buf_blz_d, disp_blz_q, disp_blz_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic        err_q, err_d;

  logic [1:0]  digit_sel;
  logic        legal;
  logic        lead_zero;
  logic        handshake;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Scan re-entered digit 0: the frame boundary.
  assign frame_tick      = (s2_q == AnodeDigit0) && (s3_q != AnodeDigit0);
  assign bus.value_ready = !pending_q && !reset;
  assign handshake       = bus.value_valid && bus.value_ready;

  assign seg       = seg_q;
  assign dp        = dp_q;
  assign anode_err = err_q;

  always_comb begin
    digit_sel = 2'd0;
    legal     = 1'b1;
    unique case (s2_q)
      4'b1110: digit_sel = 2'd0;
      4'b1101: digit_sel = 2'd1;
      4'b1011: digit_sel = 2'd2;
      4'b0111: digit_sel = 2'd3;
      default: legal = 1'b0;
    endcase

    // Digit k is a leading zero when it and every digit above it are zero.
    case (digit_sel)
      2'd1:    lead_zero = disp_blz_q && (disp_value_q[15:4] == 12'h000);
      2'd2:    lead_zero = disp_blz_q && (disp_value_q[15:8] == 8'h00);
      2'd3:    lead_zero = disp_blz_q && (disp_value_q[15:12] == 4'h0);
      default: lead_zero = 1'b0;
    endcase

    seg_d = 7'b1111111;
    dp_d  = 1'b1;
    if (legal) begin
      seg_d = lead_zero ? 7'b1111111 : hex_to_seg(disp_value_q[{digit_sel, 2'b00} +: 4]);
      dp_d  = ~disp_dp_q[digit_sel];
    end
    err_d = err_q | ~legal;

    s1_d = anode;
    s2_d = s1_q;
    s3_d = s2_q;

    pending_d    = pending_q;
    buf_value_d  = buf_value_q;
    buf_dp_d     = buf_dp_q;
    buf_blz_d    = buf_blz_q;
    disp_value_d = disp_value_q;
    disp_dp_d    = disp_dp_q;
    disp_blz_d   = disp_blz_q;
    // Capture needs an empty buffer and commit needs a full one, so they never coincide;
    // a capture on a boundary cycle therefore waits for the next boundary.
    if (handshake) begin
      pending_d   = 1'b1;
      buf_value_d = bus.value;
      buf_dp_d    = bus.dp_in;
      buf_blz_d   = bus.blank_lz;
    end else if (frame_tick && pending_q) begin
      pending_d    = 1'b0;
      disp_value_d = buf_value_q;
      disp_dp_d    = buf_dp_q;
      disp_blz_d   = buf_blz_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      // Sync chain resets to digit 0 so a scanner still held in reset is not flagged.
      s1_q         <= AnodeDigit0;
      s2_q         <= AnodeDigit0;
      s3_q         <= AnodeDigit0;
      pending_q    <= 1'b0;
      buf_value_q  <= 16'h0000;
      buf_dp_q     <= 4'h0;
      buf_blz_q    <= 1'b0;
      disp_value_q <= 16'h0000;
      disp_dp_q    <= 4'h0;
      disp_blz_q   <= 1'b0;
      seg_q        <= 7'b1111111;
      dp_q         <= 1'b1;
      err_q        <= 1'b0;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      s3_q         <= s3_d;
      pending_q    <= pending_d;
      buf_value_q  <= buf_value_d;
      buf_dp_q     <= buf_dp_d;
      buf_blz_q    <= buf_blz_d;
      disp_value_q <= disp_value_d;
      disp_dp_q    <= disp_dp_d;
      disp_blz_q   <= disp_blz_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_seven_seg_digit_driver.sv
// Bench for seven_seg_digit_driver: directed anode rotations and frame transfers, a
// frame-level reference model compared every cycle, and literal glyph checks.
module tb_seven_seg_digit_driver;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] anode = 4'b1110;
  logic [6:0] seg;
  logic       dp, frame_tick, anode_err;

  seven_seg_digit_driver_if bus ();

  always #5 clock = ~clock;

  seven_seg_digit_driver dut (
    .clock      (clock),
    .reset      (reset),
    .anode      (anode),
    .bus        (bus),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick),
    .anode_err  (anode_err)
  );

  int total = 0;
  int bad   = 0;

  // Reference state: the anode as seen 1, 2 and 3 edges ago, plus abstract frame buffers.
  logic [3:0]  samp [3];
  bit          started = 1'b0;
  logic        m_pending;
  logic [15:0] m_bval, m_dval;
  logic [3:0]  m_bdp, m_ddp;
  logic        m_bblz, m_dblz;
  logic [6:0]  m_seg;
  logic        m_dp, m_err;

  // Lit segments of each hex glyph, active-high {g,f,e,d,c,b,a}.
  function automatic logic [6:0] lit_mask(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // Expected {seg, dp} for anode pattern a showing frame (v, dps, blz).
  function automatic logic [7:0] expect_out(input logic [3:0] a, input logic [15:0] v,
                                            input logic [3:0] dps, input logic blz);
    int          k;
    logic [15:0] upper;
    logic [6:0]  s;
    logic [3:0]  inv;
    inv = ~a;
    if ($countones(inv) != 1) return {7'h7F, 1'b1};
    k = 0;
    for (int i = 0; i < 4; i++) if (!a[i]) k = i;
    upper = v >> (4 * k);
    if (blz && k > 0 && upper == 16'h0000) s = 7'h7F;
    else s = ~lit_mask(upper[3:0]);
    return {s, ~dps[k]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model, advanced on every rising edge from the pre-edge inputs.
  initial begin
    logic       boundary;
    logic [3:0] inv;
    forever begin
      @(posedge clock);
      if (reset) begin
        for (int i = 0; i < 3; i++) samp[i] = 4'b1110;
        m_pending = 1'b0;
        m_bval = '0; m_bdp = '0; m_bblz = 1'b0;
        m_dval = '0; m_ddp = '0; m_dblz = 1'b0;
        m_seg = 7'h7F; m_dp = 1'b1; m_err = 1'b0;
        started = 1'b1;
      end else begin
        {m_seg, m_dp} = expect_out(samp[1], m_dval, m_ddp, m_dblz);
        inv = ~samp[1];
        if ($countones(inv) != 1) m_err = 1'b1;
        boundary = (samp[1] == 4'b1110) && (samp[2] != 4'b1110);
        if (bus.value_valid && !m_pending) begin
          m_pending = 1'b1;
          m_bval = bus.value; m_bdp = bus.dp_in; m_bblz = bus.blank_lz;
        end else if (boundary && m_pending) begin
          m_pending = 1'b0;
          m_dval = m_bval; m_ddp = m_bdp; m_dblz = m_bblz;
        end
        samp[2] = samp[1];
        samp[1] = samp[0];
        samp[0] = anode;
      end
    end
  end

  // Every-cycle comparison against the model, mid-cycle.
  initial begin
    forever begin
      @(negedge clock);
      if (started) begin
        check("seg", 32'(seg), 32'(m_seg));
        check("dp", 32'(dp), 32'(m_dp));
        check("frame_tick", 32'(frame_tick),
              32'((samp[1] == 4'b1110) && (samp[2] != 4'b1110)));
        check("value_ready", 32'(bus.value_ready), 32'(!m_pending && !reset));
        check("anode_err", 32'(anode_err), 32'(m_err));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic hold(input logic [3:0] a, input int n);
    anode = a;
    tick(n);
  endtask

  task automatic send(input logic [15:0] v, input logic [3:0] d, input logic b);
    bit ok;
    ok = 1'b0;
    bus.value = v; bus.dp_in = d; bus.blank_lz = b; bus.value_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (bus.value_ready) begin
        tick(1);
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    bus.value_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got ready=0 expected ready=1 within 40 cycles");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish by 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.value = '0; bus.dp_in = '0; bus.blank_lz = 1'b0; bus.value_valid = 1'b0;
    tick(3);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_ready", 32'(bus.value_ready), 32'h0);
    reset = 1'b0;
    tick(1);
    check("post_rst_seg", 32'(seg), 32'h40);
    check("post_rst_dp", 32'(dp), 32'h1);
    check("post_rst_ready", 32'(bus.value_ready), 32'h1);
    check("post_rst_err", 32'(anode_err), 32'h0);

    // Frame 1A8F, dp on digit 1.
    send(16'h1A8F, 4'b0010, 1'b0);
    check("busy_after_send", 32'(bus.value_ready), 32'h0);
    hold(4'b0111, 3); hold(4'b1011, 3); hold(4'b1101, 3);
    hold(4'b1110, 4);
    check("d0_F", 32'(seg), 32'h0E);
    check("d0_dp", 32'(dp), 32'h1);
    check("ready_after_commit", 32'(bus.value_ready), 32'h1);
    hold(4'b0111, 3); check("d3_1", 32'(seg), 32'h79);
    hold(4'b1011, 3); check("d2_A", 32'(seg), 32'h08);
    hold(4'b1101, 3); check("d1_8", 32'(seg), 32'h00);
    check("d1_dp", 32'(dp), 32'h0);

    // Handshake exactly on the boundary cycle; commit waits a whole frame.
    anode = 4'b1110;
    tick(2);
    check("tick_seen", 32'(frame_tick), 32'h1);
    bus.value = 16'h0040; bus.dp_in = 4'b0000; bus.blank_lz = 1'b1; bus.value_valid = 1'b1;
    tick(1);
    bus.value_valid = 1'b0;
    check("captured_on_tick", 32'(bus.value_ready), 32'h0);
    tick(1);
    check("old_d0_kept", 32'(seg), 32'h0E);
    hold(4'b0111, 3); check("old_d3_kept", 32'(seg), 32'h79);
    hold(4'b1011, 3); hold(4'b1101, 3);
    check("old_d1_kept", 32'(seg), 32'h00);
    hold(4'b1110, 4); check("new_d0_0", 32'(seg), 32'h40);
    hold(4'b0111, 3); check("blank_d3", 32'(seg), 32'h7F);
    hold(4'b1011, 3); check("blank_d2", 32'(seg), 32'h7F);
    hold(4'b1101, 3); check("d1_4", 32'(seg), 32'h19);
    check("d1_dp_off", 32'(dp), 32'h1);

    // Illegal anode pattern.
    hold(4'b1100, 3);
    check("illegal_seg", 32'(seg), 32'h7F);
    check("illegal_dp", 32'(dp), 32'h1);
    check("illegal_err", 32'(anode_err), 32'h1);
    hold(4'b1110, 4);
    check("err_sticky", 32'(anode_err), 32'h1);

    // Reset drops a pending frame.
    send(16'h9999, 4'b1111, 1'b0);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    check("err_cleared", 32'(anode_err), 32'h0);
    check("ready_after_reset", 32'(bus.value_ready), 32'h1);
    hold(4'b0111, 3); check("lost_d3", 32'(seg), 32'h40);
    hold(4'b1011, 3); hold(4'b1101, 3);
    hold(4'b1110, 4);
    check("lost_d0", 32'(seg), 32'h40);
    check("lost_dp", 32'(dp), 32'h1);

    // All-dark anodes persisting after reset count as illegal.
    hold(4'b1111, 3);
    check("dark_err", 32'(anode_err), 32'h1);
    check("dark_seg", 32'(seg), 32'h7F);
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
